doodle_motion: RTL and testbench

//  Per-frame vertical/horizontal motion controller for the doodle sprite; consumes the 8 platform positions from the platform stage.

---
 rtl/doodle_pkg.sv | 40 ++++
 rtl/plat_land_check.sv | 53 +++++
 rtl/doodle_motion.sv | 191 +++++++++++++++++++
 tb/tb_doodle_motion.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg: shared types and constants for the doodle motion controller.
//  - state_t      : jump state machine encoding (Rise=0, Fall=1, Dead=2)
//  - geometry     : playfield bounds, sprite/platform half-widths, start point
//  - dynamics     : launch speed, fall cap, gravity divider, steering step
//  - keycodes     : USB HID codes for left, right and restart
package doodle_pkg;

  localparam int unsigned NUM_PLAT = 8;

  localparam logic [9:0] X_MIN         = 10'd80;
  localparam logic [9:0] X_MAX         = 10'd239;
  localparam logic [9:0] Y_MAX         = 10'd239;
  localparam logic [9:0] PLAT_HALF_W   = 10'd20;
  localparam logic [9:0] DOODLE_HALF_W = 10'd8;
  localparam logic [9:0] X_STEP        = 10'd2;
  localparam logic [9:0] SCROLL_LINE   = 10'd120;
  localparam logic [9:0] START_X       = 10'd160;
  localparam logic [9:0] START_Y       = 10'd200;

  localparam logic [4:0] JUMP_V   = 5'd10;
  localparam logic [4:0] V_MAX    = 5'd12;
  localparam logic [2:0] GRAV_DIV = 3'd4;
  // Gravity counter value on which the speed changes (the wrap frame).
  localparam logic [2:0] GCNT_LAST = GRAV_DIV - 3'd1;

  localparam logic [7:0] KEY_LEFT    = 8'h04;
  localparam logic [7:0] KEY_RIGHT   = 8'h07;
  localparam logic [7:0] KEY_RESTART = 8'h2C;

  typedef enum logic [1:0] {
    Rise = 2'd0,
    Fall = 2'd1,
    Dead = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

endpackage

// File: rtl/plat_land_check.sv
// plat_land_check: combinational landing detector for the falling doodle.
//  x, y      in   10  doodle centre X and feet Y before this frame's move
//  yn        in   11  feet Y after this frame's fall (two's complement)
//  plat_x/y  in   80  8 packed platform centres / tops, platform i = [10*i+9:10*i]
//  hit       out  1   feet cross at least one overlapping platform top
//  land_y    out  10  highest (smallest Y) hit platform top; lowest index on a tie
module plat_land_check
  import doodle_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [10:0] yn,
  input  logic [79:0] plat_x,
  input  logic [79:0] plat_y,
  output logic        hit,
  output logic [9:0]  land_y
);

  // All compares run 12-bit signed so platform_x - half_width cannot wrap.
  logic signed [11:0] x_s, y_s, yn_s, pw_s, dw_s;

  assign x_s  = $signed({2'b00, x});
  assign y_s  = $signed({2'b00, y});
  assign yn_s = $signed({yn[10], yn});
  assign pw_s = $signed({2'b00, PLAT_HALF_W});
  assign dw_s = $signed({2'b00, DOODLE_HALF_W});

  logic [NUM_PLAT-1:0] hit_vec;
  logic [9:0]          py_arr [NUM_PLAT];

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_plat
    logic signed [11:0] px_s, py_s;
    assign px_s       = $signed({2'b00, plat_x[10*g +: 10]});
    assign py_s       = $signed({2'b00, plat_y[10*g +: 10]});
    assign py_arr[g]  = plat_y[10*g +: 10];
    assign hit_vec[g] = (px_s - pw_s <= x_s + dw_s) &&
                        (x_s - dw_s <= px_s + pw_s) &&
                        (y_s <= py_s) && (yn_s >= py_s);
  end

  // Strict '<' keeps the lowest-index platform when tops are equal.
  always_comb begin
    hit    = 1'b0;
    land_y = '0;
    for (int i = 0; i < int'(NUM_PLAT); i++) begin
      if (hit_vec[i] && (!hit || (py_arr[i] < land_y))) begin
        hit    = 1'b1;
        land_y = py_arr[i];
      end
    end
  end

endmodule

// File: rtl/doodle_motion.sv
// doodle_motion: per-frame motion controller for the doodle sprite.
//  frame_clk    in   1   one rising edge per video frame
//  Reset        in   1   synchronous, active-high
//  keycode      in   8   8'h04 left, 8'h07 right, 8'h2C restart (from Dead)
//  plat_x/y     in   80  8 packed platform centres / tops from the platform stage
//  doodle_x     out  10  doodle centre X
//  doodle_y     out  10  doodle feet Y
//  state        out  2   Rise=0, Fall=1, Dead=2
//  scroll_dist  out  10  rows the world scrolls down next frame
//  score        out  16  saturating landing count
//  game_over    out  1   high while in Dead
// All outputs are registered; each frame uses the values held at the edge.
module doodle_motion
  import doodle_pkg::*;
(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [79:0] plat_x,
  input  logic [79:0] plat_y,
  output logic [9:0]  doodle_x,
  output logic [9:0]  doodle_y,
  output logic [1:0]  state,
  output logic [9:0]  scroll_dist,
  output logic [15:0] score,
  output logic        game_over
);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [4:0]  v_q, v_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic [9:0]  scroll_q, scroll_d;
  logic [15:0] score_q, score_d;
  logic        go_q, go_d;

  // Vertical candidates, 11 bits so a rise above row 0 stays visible as negative.
  logic [10:0] yn_rise, yn_fall;
  logic        rise_clamp, fall_out;
  logic        gwrap;
  logic [2:0]  gcnt_inc;

  assign yn_rise    = {1'b0, y_q} - {6'b0, v_q};
  assign yn_fall    = {1'b0, y_q} + {6'b0, v_q};
  assign rise_clamp = $signed(yn_rise) < $signed({1'b0, SCROLL_LINE});
  assign fall_out   = yn_fall > {1'b0, Y_MAX};
  assign gwrap      = (gcnt_q == GCNT_LAST);
  assign gcnt_inc   = gwrap ? 3'd0 : gcnt_q + 3'd1;

  // Steering with wrap-around at the playfield edges.
  logic [10:0] xn;
  logic [9:0]  x_wrap;

  always_comb begin
    case (keycode)
      KEY_LEFT:  xn = {1'b0, x_q} - {1'b0, X_STEP};
      KEY_RIGHT: xn = {1'b0, x_q} + {1'b0, X_STEP};
      default:   xn = {1'b0, x_q};
    endcase
    if ($signed(xn) < $signed({1'b0, X_MIN})) begin
      x_wrap = X_MAX;
    end else if ($signed(xn) > $signed({1'b0, X_MAX})) begin
      x_wrap = X_MIN;
    end else begin
      x_wrap = xn[9:0];
    end
  end

  // Landing test uses the pre-move x and the post-fall feet row.
  logic       hit;
  logic [9:0] land_y;

  plat_land_check u_land (
    .x      (x_q),
    .y      (y_q),
    .yn     (yn_fall),
    .plat_x (plat_x),
    .plat_y (plat_y),
    .hit    (hit),
    .land_y (land_y)
  );

  // State register, including the synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= Rise;
      x_q      <= START_X;
      y_q      <= START_Y;
      v_q      <= JUMP_V;
      gcnt_q   <= 3'd0;
      scroll_q <= 10'd0;
      score_q  <= 16'd0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      v_q      <= v_d;
      gcnt_q   <= gcnt_d;
      scroll_q <= scroll_d;
      score_q  <= score_d;
      go_q     <= go_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Rise: if (gwrap && (v_q <= 5'd1)) state_d = Fall;
      Fall: begin
        if (hit) begin
          state_d = Rise;
        end else if (fall_out) begin
          state_d = Dead;
        end
      end
      Dead: if (keycode == KEY_RESTART) state_d = Rise;
      default: state_d = Dead;
    endcase
  end

  // Datapath next values.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    v_d      = v_q;
    gcnt_d   = gcnt_q;
    scroll_d = 10'd0;
    score_d  = score_q;
    go_d     = go_q;
    unique case (state_q)
      Rise: begin
        x_d    = x_wrap;
        gcnt_d = gcnt_inc;
        if (rise_clamp) begin
          // Doodle pinned at the scroll line; the world moves instead.
          y_d      = SCROLL_LINE;
          scroll_d = SCROLL_LINE - yn_rise[9:0];
        end else begin
          y_d = yn_rise[9:0];
        end
        if (gwrap) begin
          v_d = (v_q <= 5'd1) ? 5'd0 : v_q - 5'd1;
        end
      end
      Fall: begin
        x_d = x_wrap;
        if (hit) begin
          y_d     = land_y;
          v_d     = JUMP_V;
          gcnt_d  = 3'd0;
          score_d = sat_inc16(score_q);
        end else if (fall_out) begin
          y_d    = Y_MAX;
          go_d   = 1'b1;
          gcnt_d = gcnt_inc;
        end else begin
          y_d    = yn_fall[9:0];
          gcnt_d = gcnt_inc;
          if (gwrap && (v_q < V_MAX)) begin
            v_d = v_q + 5'd1;
          end
        end
      end
      Dead: begin
        if (keycode == KEY_RESTART) begin
          x_d     = START_X;
          y_d     = START_Y;
          v_d     = JUMP_V;
          gcnt_d  = 3'd0;
          score_d = 16'd0;
          go_d    = 1'b0;
        end
      end
      default: go_d = 1'b1;
    endcase
  end

  // Outputs straight from registers.
  always_comb begin
    doodle_x    = x_q;
    doodle_y    = y_q;
    state       = state_q;
    scroll_dist = scroll_q;
    score       = score_q;
    game_over   = go_q;
  end

endmodule

// File: tb/tb_doodle_motion.sv
module tb_doodle_motion;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [79:0] plat_x;
  logic [79:0] plat_y;
  logic [9:0]  doodle_x;
  logic [9:0]  doodle_y;
  logic [1:0]  state;
  logic [9:0]  scroll_dist;
  logic [15:0] score;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  doodle_motion dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .plat_x      (plat_x),
    .plat_y      (plat_y),
    .doodle_x    (doodle_x),
    .doodle_y    (doodle_y),
    .state       (state),
    .scroll_dist (scroll_dist),
    .score       (score),
    .game_over   (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  // Advance n frames; sample 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic clear_plats();
    plat_x = '0;
    plat_y = '0;
  endtask

  task automatic set_plat(input int i, input logic [9:0] px, input logic [9:0] py);
    plat_x[10*i +: 10] = px;
    plat_y[10*i +: 10] = py;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    keycode = 8'h00;
    step(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_plats();
    do_reset();
    checks++; if (doodle_x !== 10'd160) begin errors++;
      $display("FAIL rst_x got %0d exp 160", doodle_x); end
    checks++; if (doodle_y !== 10'd200) begin errors++;
      $display("FAIL rst_y got %0d exp 200", doodle_y); end
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (scroll_dist !== 10'd0) begin errors++;
      $display("FAIL rst_scroll got %0d exp 0", scroll_dist); end
    checks++; if (score !== 16'd0) begin errors++;
      $display("FAIL rst_score got %0d exp 0", score); end
    checks++; if (game_over !== 1'b0) begin errors++;
      $display("FAIL rst_go got %0d exp 0", game_over); end
    step(1);
    checks++; if (doodle_x !== 10'd160 || doodle_y !== 10'd190 || state !== 2'd0) begin
      errors++;
      $display("FAIL idle1 got x=%0d y=%0d st=%0d exp 160/190/0", doodle_x, doodle_y, state);
    end
    checks++; if (scroll_dist !== 10'd0 || score !== 16'd0) begin errors++;
      $display("FAIL idle1_sc got scroll=%0d score=%0d exp 0/0", scroll_dist, score); end
  endtask

  // Continues from test_reset: currently one frame after reset.
  task automatic test_gravity_and_death();
    step(3);  // frame 4
    checks++; if (doodle_y !== 10'd160) begin errors++;
      $display("FAIL grav_f4 y got %0d exp 160", doodle_y); end
    step(4);  // frame 8
    checks++; if (doodle_y !== 10'd124 || scroll_dist !== 10'd0) begin errors++;
      $display("FAIL grav_f8 got y=%0d scroll=%0d exp 124/0", doodle_y, scroll_dist); end
    step(1);  // frame 9: 124-8=116 clamps
    checks++; if (doodle_y !== 10'd120 || scroll_dist !== 10'd4) begin errors++;
      $display("FAIL scroll_f9 got y=%0d scroll=%0d exp 120/4", doodle_y, scroll_dist); end
    step(3);  // frame 12
    checks++; if (scroll_dist !== 10'd8) begin errors++;
      $display("FAIL scroll_f12 got %0d exp 8", scroll_dist); end
    step(1);  // frame 13: speed dropped to 7
    checks++; if (scroll_dist !== 10'd7) begin errors++;
      $display("FAIL scroll_f13 got %0d exp 7", scroll_dist); end
    step(27); // frame 40: v hits 0 -> Fall
    checks++; if (state !== 2'd1 || doodle_y !== 10'd120 || scroll_dist !== 10'd1) begin
      errors++;
      $display("FAIL apex_f40 got st=%0d y=%0d scroll=%0d exp 1/120/1",
               state, doodle_y, scroll_dist);
    end
    step(1);  // frame 41: v=0, y holds
    checks++; if (state !== 2'd1 || doodle_y !== 10'd120 || scroll_dist !== 10'd0) begin
      errors++;
      $display("FAIL hover_f41 got st=%0d y=%0d scroll=%0d exp 1/120/0",
               state, doodle_y, scroll_dist);
    end
    step(31); // frame 72
    checks++; if (doodle_y !== 10'd232 || state !== 2'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL fall_f72 got y=%0d st=%0d go=%0d exp 232/1/0", doodle_y, state, game_over);
    end
    step(1);  // frame 73: 232+8=240 > 239
    checks++; if (state !== 2'd2 || doodle_y !== 10'd239 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL death got st=%0d y=%0d go=%0d exp 2/239/1", state, doodle_y, game_over);
    end
    keycode = 8'h04;
    step(2);
    keycode = 8'h00;
    checks++; if (doodle_x !== 10'd160 || doodle_y !== 10'd239 || state !== 2'd2 ||
                  scroll_dist !== 10'd0) begin
      errors++;
      $display("FAIL dead_hold got x=%0d y=%0d st=%0d scroll=%0d exp 160/239/2/0",
               doodle_x, doodle_y, state, scroll_dist);
    end
  endtask

  task automatic test_landing_and_restart();
    int n;
    clear_plats();
    set_plat(3, 10'd150, 10'd228);
    set_plat(5, 10'd170, 10'd230);
    set_plat(0, 10'd100, 10'd226);  // y-crossed but no x overlap
    do_reset();
    step(72); // frame 72: y 225 -> 232 crosses 226/228/230
    checks++; if (doodle_y !== 10'd228 || state !== 2'd0 || score !== 16'd1) begin errors++;
      $display("FAIL land got y=%0d st=%0d score=%0d exp 228/0/1", doodle_y, state, score); end
    step(1);
    checks++; if (doodle_y !== 10'd218) begin errors++;
      $display("FAIL relaunch got y=%0d exp 218", doodle_y); end
    step(4);  // gcnt restarted at 0, so v=9 from here
    checks++; if (doodle_y !== 10'd179) begin errors++;
      $display("FAIL relaunch_g got y=%0d exp 179", doodle_y); end
    step(7);  // exactly reaches 120: no scroll
    checks++; if (doodle_y !== 10'd120 || scroll_dist !== 10'd0) begin errors++;
      $display("FAIL line_eq got y=%0d scroll=%0d exp 120/0", doodle_y, scroll_dist); end
    step(1);
    checks++; if (doodle_y !== 10'd120 || scroll_dist !== 10'd7) begin errors++;
      $display("FAIL line_over got y=%0d scroll=%0d exp 120/7", doodle_y, scroll_dist); end
    clear_plats();
    n = 0;
    while (game_over !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    checks++; if (game_over !== 1'b1 || doodle_y !== 10'd239 || score !== 16'd1) begin
      errors++;
      $display("FAIL die2 got go=%0d y=%0d score=%0d exp 1/239/1", game_over, doodle_y, score);
    end
    keycode = 8'h2C;
    step(1);
    keycode = 8'h00;
    checks++; if (doodle_x !== 10'd160 || doodle_y !== 10'd200 || state !== 2'd0) begin
      errors++;
      $display("FAIL restart got x=%0d y=%0d st=%0d exp 160/200/0", doodle_x, doodle_y, state);
    end
    checks++; if (score !== 16'd0 || game_over !== 1'b0) begin errors++;
      $display("FAIL restart_sc got score=%0d go=%0d exp 0/0", score, game_over); end
    step(1);
    checks++; if (doodle_y !== 10'd190) begin errors++;
      $display("FAIL restart_v got y=%0d exp 190", doodle_y); end
  endtask

  task automatic test_steering();
    clear_plats();
    do_reset();
    keycode = 8'h04;
    step(1);
    checks++; if (doodle_x !== 10'd158) begin errors++;
      $display("FAIL left got %0d exp 158", doodle_x); end
    step(39);
    checks++; if (doodle_x !== 10'd80) begin errors++;
      $display("FAIL left_min got %0d exp 80", doodle_x); end
    step(1);
    checks++; if (doodle_x !== 10'd239) begin errors++;
      $display("FAIL wrap_left got %0d exp 239", doodle_x); end
    keycode = 8'h07;
    step(1);
    checks++; if (doodle_x !== 10'd80) begin errors++;
      $display("FAIL wrap_right got %0d exp 80", doodle_x); end
    keycode = 8'h00;
    step(1);
    checks++; if (doodle_x !== 10'd80) begin errors++;
      $display("FAIL nokey got %0d exp 80", doodle_x); end
    keycode = 8'h07;
    step(1);
    keycode = 8'h00;
    checks++; if (doodle_x !== 10'd82) begin errors++;
      $display("FAIL right got %0d exp 82", doodle_x); end
  endtask

  task automatic test_land_at_ymax();
    clear_plats();
    set_plat(7, 10'd160, 10'd239);
    do_reset();
    step(72);
    checks++; if (doodle_y !== 10'd232 || state !== 2'd1) begin errors++;
      $display("FAIL ymax_pre got y=%0d st=%0d exp 232/1", doodle_y, state); end
    step(1);  // 240 would die, but the row-239 platform catches it first
    checks++; if (doodle_y !== 10'd239 || state !== 2'd0 || score !== 16'd1 ||
                  game_over !== 1'b0) begin
      errors++;
      $display("FAIL ymax_land got y=%0d st=%0d score=%0d go=%0d exp 239/0/1/0",
               doodle_y, state, score, game_over);
    end
  endtask

  // Continues from test_land_at_ymax with score=1.
  task automatic test_reset_mid_fall();
    int n;
    n = 0;
    while (state !== 2'd1 && n < 200) begin
      step(1);
      n++;
    end
    checks++; if (state !== 2'd1) begin errors++;
      $display("FAIL reach_fall got st=%0d exp 1", state); end
    keycode = 8'h07;
    Reset   = 1'b1;
    step(1);
    checks++; if (doodle_x !== 10'd160 || doodle_y !== 10'd200 || state !== 2'd0) begin
      errors++;
      $display("FAIL midrst got x=%0d y=%0d st=%0d exp 160/200/0", doodle_x, doodle_y, state);
    end
    checks++; if (score !== 16'd0 || scroll_dist !== 10'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL midrst_sc got score=%0d scroll=%0d go=%0d exp 0/0/0",
               score, scroll_dist, game_over);
    end
    Reset   = 1'b0;
    keycode = 8'h00;
  endtask

  initial begin
    Reset   = 1'b0;
    keycode = 8'h00;
    plat_x  = '0;
    plat_y  = '0;
    test_reset();
    test_gravity_and_death();
    test_landing_and_restart();
    test_steering();
    test_land_at_ymax();
    test_reset_mid_fall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
